// File: rtl/logic_reduce.sv
// Packet-wide bitwise reduction (AND/OR/XOR and inverted forms) over a
// valid/ready input stream, with the result held until downstream accepts it.
module logic_reduce #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             accept;

    // Inverted ops and reserved codes share the base AND/OR/XOR fold.
    function automatic logic [WIDTH-1:0] fold(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (op)
            3'd1, 3'd4: fold = a | b;
            3'd2, 3'd5: fold = a ^ b;
            default:    fold = a & b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] finish(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a);
        finish = (op >= 3'd3 && op <= 3'd5) ? ~a : a;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    op_d    = in_op;
                    cnt_d   = CW'(1);
                    err_d   = (in_op > 3'd5);
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = fold(op_q, acc_q, in_data);
                    // Overlong packets keep folding but pin the count and flag it.
                    if (cnt_q == CW'(MAX_LEN)) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data  = out_valid ? finish(op_q, acc_q) : '0;
    assign out_count = out_valid ? cnt_q : '0;
    assign out_err   = out_valid ? err_q : 1'b0;

endmodule
